// File: rtl/dm_alloc_pkg.sv
// Shared types for the DM slot allocator: address type, error codes and the
// allocate-response record.
package dm_alloc_pkg;

  typedef logic [63:0] dm_addr_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    RANGE  = 2'd1,
    DOUBLE = 2'd2
  } dm_alloc_err_e;

  typedef struct packed {
    logic     ok;
    dm_addr_t addr;
  } dm_alloc_rsp_t;

endpackage

// File: rtl/dm_ffs.sv
// Find-first-clear priority encoder: reports the lowest index whose bit is 0.
// Purely combinational.
module dm_ffs #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         busy_i,
  output logic                     found_o,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW = $clog2(WIDTH);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the lowest clear bit is the last one to win.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!busy_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dm_slot_allocator.sv
// Hardware responder for the DM allocator protocol: grants the lowest free
// unit-sized address from a pool of SLOTS starting at BASE and accepts frees.
// Optional invalid-free reporting is enabled with DM_ALLOC_ERR_CHECK_EN.
module dm_slot_allocator
  import dm_alloc_pkg::*;
#(
  parameter dm_addr_t BASE  = 64'd1,
  parameter int       SLOTS = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_ok,
  output logic [63:0]                rsp_addr,
  input  logic                       free_valid,
  input  logic [63:0]                free_addr,
  output logic [$clog2(SLOTS+1)-1:0] used_count,
  output logic                       full,
  output logic                       empty,
  output logic                       err_valid,
  output logic [1:0]                 err_code
);

  localparam int IW = $clog2(SLOTS);
  localparam int CW = $clog2(SLOTS + 1);

  logic [SLOTS-1:0] busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  dm_alloc_rsp_t    rsp_q, rsp_d;
  logic [CW-1:0]    used_q, used_d;

  logic          ffs_found;
  logic [IW-1:0] ffs_idx;
  logic          accept, grant;
  dm_addr_t      free_off;
  logic [IW-1:0] free_idx;
  logic          free_in_range, free_hit, free_ok;
  logic          unused_free_hi;

  dm_ffs #(.WIDTH(SLOTS)) u_ffs (
    .busy_i  (busy_q),
    .found_o (ffs_found),
    .idx_o   (ffs_idx)
  );

  assign alloc_ready = !rsp_valid_q || rsp_ready;
  assign accept      = alloc_valid && alloc_ready;
  assign grant       = accept && ffs_found;

  // Both the allocator and the free check look at the pre-free bitmap, so a
  // free of the slot being granted this cycle is seen as a double free.
  assign free_off       = free_addr - BASE;
  assign free_idx       = free_off[IW-1:0];
  assign unused_free_hi = ^free_off[63:IW];
  assign free_in_range  = (free_addr >= BASE) && (free_off < dm_addr_t'(SLOTS));
  assign free_hit       = free_in_range && busy_q[free_idx];
  assign free_ok        = free_valid && free_hit;

  always_comb begin
    busy_d      = busy_q;
    used_d      = used_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (grant)   busy_d[ffs_idx]  = 1'b1;
    if (free_ok) busy_d[free_idx] = 1'b0;

    unique case ({grant, free_ok})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase

    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_d.ok    = ffs_found;
      rsp_d.addr  = ffs_found ? BASE + dm_addr_t'(ffs_idx) : '0;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only; the busy bitmap
  // is ordinary flops (not a RAM), so it is cleared by reset like the rest.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= '0;
      used_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      used_q      <= used_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_ok     = rsp_q.ok;
  assign rsp_addr   = rsp_q.addr;
  assign used_count = used_q;
  assign full       = (used_q == CW'(SLOTS));
  assign empty      = (used_q == '0);

`ifdef DM_ALLOC_ERR_CHECK_EN
  logic          err_valid_q, err_valid_d;
  dm_alloc_err_e err_code_q, err_code_d;

  always_comb begin
    err_valid_d = free_valid && !free_hit;
    err_code_d  = err_code_q;
    if (err_valid_d) err_code_d = free_in_range ? DOUBLE : RANGE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_q <= 1'b0;
      err_code_q  <= NONE;
    end else begin
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
`else
  assign err_valid = 1'b0;
  assign err_code  = 2'b00;
`endif

endmodule

// File: doc/dm_slot_allocator.md
# dm_slot_allocator

Synthesizable responder for the DM allocator protocol. It owns a pool of SLOTS single-granule addresses starting at BASE and answers allocate requests with the lowest free address. It accepts free requests that return addresses to the pool. It serves as the hardware-side counterpart of the DPI allocator used by the simulation benches, so RTL clients allocate and free addresses with identical semantics (base 1, size 16, unit size, unit alignment).

## Interface
- BASE, 64'd1, address of slot 0.
- SLOTS, 16, pool size (2..64).
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  allocate request.
- alloc_ready  out  1  request accepted when alloc_valid & alloc_ready.
- rsp_valid  out  1  allocate response valid.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_ok  out  1  1 = address granted, 0 = pool exhausted.
- rsp_addr  out  64  granted address (0 when rsp_ok=0).
- free_valid  in  1  free request, single-cycle, always accepted.
- free_addr  in  64  address to free.
- used_count  out  $clog2(SLOTS+1)  number of busy slots.
- full  out  1  used_count == SLOTS.
- empty  out  1  used_count == 0.
- err_valid  out  1  one-cycle error pulse (see Configuration).
- err_code  out  2  0 none, 1 out-of-range free, 2 double free.

## Operation
- State: busy bitmap[SLOTS], one-entry response register (rsp_valid/rsp_ok/rsp_addr), used counter.
- alloc_ready = !rsp_valid | rsp_ready. At most one request is outstanding, with full throughput when the consumer always accepts.
- On accept: idx = lowest clear bit of bitmap (pre-free value). If found: set bit, rsp_ok=1, rsp_addr=BASE+idx. Else: rsp_ok=0, rsp_addr=0, bitmap unchanged.
- Free: idx = free_addr-BASE, 64-bit unsigned. Valid only if free_addr >= BASE, idx < SLOTS and bit set; then the bit is cleared. Otherwise no state change.
- Same cycle alloc and free: the allocator sees the bitmap before the free, so a freed slot is reusable from the next cycle. A free of the slot being granted in the same cycle is a double free.
- used_count: +1 on successful grant, −1 on valid free; both in one cycle means no change. Never wraps: saturates to 0..SLOTS by construction.
- full/empty are combinational from used_count.

## Timing
- Response latency 1: request accepted at edge N gives rsp_valid high after edge N. Response is held stable until consumed.
- Free takes effect at the accepting edge; used_count/full/empty reflect it after that edge.
- Reset (async assert, sync deassert expected upstream): bitmap 0, rsp_valid 0, rsp_ok 0, rsp_addr 0, used_count 0, err_valid 0, err_code 0. alloc_ready=1 and empty=1 out of reset.
- Reset mid-operation drops any pending response and frees all slots. Clients must discard outstanding grants.

## Configuration
- DM_ALLOC_ERR_CHECK_EN defined: an invalid free pulses err_valid for one cycle after the edge, with err_code 1 (out-of-range) or 2 (double free). err_code holds its last value until the next error or reset.
- Not defined: invalid frees are silently ignored, and err_valid/err_code are tied 0. Allocation behaviour is identical in both builds.

## Structure
- Package dm_alloc_pkg: typedef dm_addr_t (64-bit), enum dm_alloc_err_e {NONE, RANGE, DOUBLE}, typedef struct dm_alloc_rsp_t {ok, addr}.
- Sub-module dm_ffs: parameterized find-first-clear priority encoder (width SLOTS → found, index). It is purely combinational and instantiated once.

## Test plan
- Reset, then 8 back-to-back allocs with rsp_ready=1 → addresses 0x1..0x8, rsp_ok=1, used_count=8.
- Free 0x1..0x8 one per cycle → used_count falls to 0, empty=1. Next alloc returns 0x1.
- 16 allocs fill the pool (full=1), then a 17th → rsp_ok=0, rsp_addr=0, used_count stays 16.
- Hold rsp_ready=0 for 3 cycles with alloc_valid high → alloc_ready=0 and response stable. Release → next grant issued the following cycle.
- Same cycle: free 0x3 and alloc with slots 1..4 busy → grant 0x5. Next alloc → 0x3.
- With DM_ALLOC_ERR_CHECK_EN: free 0x0 → err_code 1. Free 0x11 → err_code 1. Free 0x2 twice → second gives err_code 2, used_count unchanged. Without the macro: err_valid stays 0.
